// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the MIPS front end.
//   * Opcode constants that the control unit decodes from instr[31:26].
//   * NOP_INSTR: the bubble word (sll $0,$0,0), which writes only $0.
//   * fetch_state_e: states of the instruction-fetch controller.
//   * opcode_of(): extracts the primary opcode field from an instruction.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg -- IF/ID pipeline register.
// Holds the fetched instruction, its PC+4 and a valid flag.
// Control precedence: flush_i (insert bubble) > load_i (capture) > hold.
// A flush does not touch pc4_q; a bubble's PC+4 is never consumed.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_i, flush_i     capture new contents / replace with bubble
//   instr_i, pc4_i      incoming instruction word and its PC+4
//   valid_o, instr_o,
//   pc4_o               registered IF/ID contents
module if_id_reg #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc4_o
);

  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage -- MIPS instruction fetch plus IF/ID register.
// Owns the PC and a BOOT/RUN/HALT controller, reads instruction memory
// and feeds the decoder through IF/ID (id_opcode = id_instr[31:26]).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req/imem_addr               read request, address = current PC
//   imem_ready/imem_rdata            read data valid / instruction word
//   stall                            hold PC and IF/ID
//   branch_taken/branch_target       redirect + flush (beats stall)
//   halt_req                         stop fetching until reset
//   id_valid/id_instr/id_opcode/id_pc4  IF/ID contents to decode
//   halted                           controller is in HALT
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating counters
//   perf_fetched (accept cycles) and perf_bubbles (RUN cycles writing a
//   bubble: halt, branch, memory not ready).
module fetch_if_id_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [5:0]        id_opcode,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ifid_load;
  logic              ifid_flush;

  // Wraps modulo 2^ADDR_W by construction of the width.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & WORD_MASK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    imem_req   = 1'b0;
    case (state_q)
      // One idle cycle after reset release before the first request.
      BOOT: state_d = RUN;
      RUN: begin
        imem_req = 1'b1;
        if (halt_req) begin
          state_d    = HALT;
          ifid_flush = 1'b1;
        end else if (branch_taken) begin
          // Same-cycle read data belongs to the wrong path: drop it.
          pc_d       = branch_target & WORD_MASK;
          ifid_flush = 1'b1;
        end else if (stall) begin
          // Hold everything; the current address is refetched later.
        end else if (imem_ready) begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      HALT: ; // terminal until reset; IF/ID already holds a bubble
      default: state_d = BOOT;
    endcase
  end

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (imem_rdata),
    .pc4_i   (pc_plus4),
    .valid_o (id_valid),
    .instr_o (id_instr),
    .pc4_o   (id_pc4)
  );

  assign id_opcode = opcode_of(id_instr);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetched_q, bubbles_q;

  // Every IF/ID flush happens in RUN, so ifid_flush marks bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (ifid_load && (fetched_q != 32'hFFFF_FFFF))
        fetched_q <= fetched_q + 32'd1;
      if (ifid_flush && (bubbles_q != 32'hFFFF_FFFF))
        bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Self-checking bench for fetch_if_id_stage: a vector table applied in a
// loop with expected IF/ID contents queued on drive and checked after
// the clock edge, plus hand-written reset/startup sequences.
module tb_fetch_if_id_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_if_id_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode),
    .id_pc4        (id_pc4),
    .halted        (halted)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  // Instruction memory: word tagged with its own address, opcode by slot.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0:    op = OP_ADDI;
      3'd1:    op = OP_LW;
      3'd2:    op = OP_BEQ;
      3'd3:    op = OP_SW;
      default: op = OP_RTYPE;
    endcase
    return {op, 10'h001, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    string       name;
    logic        halt;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic h, input logic b,
                              input logic [31:0] t, input logic s,
                              input logic r, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic eh);
    vec_t v;
    v.name = nm; v.halt = h; v.br = b; v.tgt = t; v.stall = s; v.ready = r;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
    v.e_pc4 = ep; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  localparam int NV = 17;
  vec_t tbl[NV];
  vec_t sb_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   n;

    //            name        hlt br tgt           stl rdy req addr          vld instr                 pc4           hlt
    tbl[0]  = mk("boot",      0, 0, 32'h0,        0, 1, 0, 32'h0,        0, NOP_INSTR,             32'h0,        0);
    tbl[1]  = mk("fetch0",    0, 0, 32'h0,        0, 1, 1, 32'h0,        1, mem_word(32'h0),       32'h4,        0);
    tbl[2]  = mk("fetch4",    0, 0, 32'h0,        0, 1, 1, 32'h4,        1, mem_word(32'h4),       32'h8,        0);
    tbl[3]  = mk("stall1",    0, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h8C01_0004,         32'h8,        0);
    tbl[4]  = mk("stall2",    0, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h8C01_0004,         32'h8,        0);
    tbl[5]  = mk("stall3",    0, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h8C01_0004,         32'h8,        0);
    tbl[6]  = mk("resume8",   0, 0, 32'h0,        0, 1, 1, 32'h8,        1, mem_word(32'h8),       32'hC,        0);
    tbl[7]  = mk("br_stall",  0, 1, 32'h43,       1, 1, 1, 32'hC,        0, NOP_INSTR,             32'hC,        0);
    tbl[8]  = mk("notrdy1",   0, 0, 32'h0,        0, 0, 1, 32'h40,       0, NOP_INSTR,             32'hC,        0);
    tbl[9]  = mk("notrdy2",   0, 0, 32'h0,        0, 0, 1, 32'h40,       0, NOP_INSTR,             32'hC,        0);
    tbl[10] = mk("fetch40",   0, 0, 32'h0,        0, 1, 1, 32'h40,       1, mem_word(32'h40),      32'h44,       0);
    tbl[11] = mk("br_top",    0, 1, 32'hFFFF_FFFC,0, 1, 1, 32'h44,       0, NOP_INSTR,             32'h44,       0);
    tbl[12] = mk("fetchtop",  0, 0, 32'h0,        0, 1, 1, 32'hFFFF_FFFC,1, mem_word(32'hFFFF_FFFC),32'h0,       0);
    tbl[13] = mk("wrap0",     0, 0, 32'h0,        0, 1, 1, 32'h0,        1, mem_word(32'h0),       32'h4,        0);
    tbl[14] = mk("halt",      1, 0, 32'h0,        0, 1, 1, 32'h4,        0, NOP_INSTR,             32'h4,        1);
    tbl[15] = mk("halt_br",   0, 1, 32'h80,       1, 1, 0, 32'h4,        0, NOP_INSTR,             32'h4,        1);
    tbl[16] = mk("halt_idle", 1, 0, 32'h0,        0, 1, 0, 32'h4,        0, NOP_INSTR,             32'h4,        1);

    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",    {31'b0, imem_req}, 32'h0);
    chk("rst_addr",   imem_addr,         32'h0);
    chk("rst_valid",  {31'b0, id_valid}, 32'h0);
    chk("rst_instr",  id_instr,          NOP_INSTR);
    chk("rst_pc4",    id_pc4,            32'h0);
    chk("rst_halted", {31'b0, halted},   32'h0);
    $display("reset state checked");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      halt_req      = tbl[i].halt;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      stall         = tbl[i].stall;
      imem_ready    = tbl[i].ready;
      #1;
      chk({tbl[i].name, "_req"}, {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req)
        chk({tbl[i].name, "_addr"}, imem_addr, tbl[i].e_addr);
      sb_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({e.name, "_valid"},  {31'b0, id_valid}, {31'b0, e.e_valid});
      chk({e.name, "_instr"},  id_instr,          e.e_instr);
      chk({e.name, "_opcode"}, {26'b0, id_opcode}, {26'b0, e.e_instr[31:26]});
      chk({e.name, "_pc4"},    id_pc4,            e.e_pc4);
      chk({e.name, "_halted"}, {31'b0, halted},   {31'b0, e.e_halted});
      $display("vec %0d %s: addr=%h valid=%0b instr=%h pc4=%h halted=%0b",
               i, e.name, imem_addr, id_valid, id_instr, id_pc4, halted);
    end

`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetched", perf_fetched, 32'd6);
    chk("perf_bubbles", perf_bubbles, 32'd5);
`endif

    // Asynchronous reset in the middle of a HALT cycle, no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_halt_rst_req",    {31'b0, imem_req}, 32'h0);
    chk("mid_halt_rst_addr",   imem_addr,         32'h0);
    chk("mid_halt_rst_halted", {31'b0, halted},   32'h0);
    chk("mid_halt_rst_valid",  {31'b0, id_valid}, 32'h0);
    chk("mid_halt_rst_instr",  id_instr,          NOP_INSTR);
    chk("mid_halt_rst_pc4",    id_pc4,            32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("mid_halt_rst_perf", perf_fetched | perf_bubbles, 32'h0);
`endif
    $display("async reset during HALT checked");

    // Startup latency: one idle BOOT cycle, then the first accept.
    halt_req = 1'b0; branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_req_low", {31'b0, imem_req}, 32'h0);
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (id_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) n = 7;
    chk("first_instr_edge", n, 32'd2);
    chk("first_instr_word", id_instr, mem_word(32'h0));
    $display("startup: first instruction at edge %0d, instr=%h", n, id_instr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
